// File: rtl/scan_addr_gen.sv
// 3-bit scan address generator feeding the A2..A0 selects of a 3-to-8 decoder.
// Auto mode advances from a DIV-clock prescaler; manual mode advances once per synchronized step edge.
module scan_addr_gen #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned LAST = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic mode,
    input  logic dir,
    input  logic step,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic tick,
    output logic wrap
);

    localparam logic [7:0] PC_TC  = 8'(DIV - 1);
    localparam logic [2:0] LAST_A = 3'(LAST);

    logic [2:0] addr_q, addr_d;
    logic [7:0] pc_q, pc_d;
    logic       s1_q, s2_q, s3_q;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;
    logic       adv;

    always_comb begin
        addr_d = addr_q;
        pc_d   = pc_q;
        adv    = 1'b0;
        wrap_d = 1'b0;
        if (en) begin
            if (mode) begin
                pc_d = 8'd0;
                adv  = s2_q & ~s3_q;
            end else if (pc_q == PC_TC) begin
                pc_d = 8'd0;
                adv  = 1'b1;
            end else begin
                pc_d = pc_q + 8'd1;
            end
        end
        // dir is only looked at on the advancing edge, so a mid-count flip takes effect next advance
        if (adv) begin
            if (!dir) begin
                if (addr_q == LAST_A) begin
                    addr_d = 3'd0;
                    wrap_d = 1'b1;
                end else begin
                    addr_d = addr_q + 3'd1;
                end
            end else begin
                if (addr_q == 3'd0) begin
                    addr_d = LAST_A;
                    wrap_d = 1'b1;
                end else begin
                    addr_d = addr_q - 3'd1;
                end
            end
        end
        tick_d = adv;
    end

    // The step synchronizer keeps sampling while disabled so stale edges are consumed, not deferred
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 3'd0;
            pc_q   <= 8'd0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pc_q   <= pc_d;
            s1_q   <= step;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign A0   = addr_q[0];
    assign A1   = addr_q[1];
    assign A2   = addr_q[2];
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Randomized scoreboard bench for scan_addr_gen; two instances (DIV=4/LAST=7 and DIV=1/LAST=5)
// share stimulus, and each tick is checked against a queue filled by a behavioural model.
module tb_scan_addr_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, mode = 1'b0, dir = 1'b0, step = 1'b0;
    logic a0_0, a1_0, a2_0, tk_0, wr_0;
    logic a0_1, a1_1, a2_1, tk_1, wr_1;

    always #5 clk = ~clk;

    scan_addr_gen #(.DIV(4), .LAST(7)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step(step),
        .A0(a0_0), .A1(a1_0), .A2(a2_0), .tick(tk_0), .wrap(wr_0));

    scan_addr_gen #(.DIV(1), .LAST(5)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step(step),
        .A0(a0_1), .A1(a1_1), .A2(a2_1), .tick(tk_1), .wrap(wr_1));

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    int divs  [2] = '{4, 1};
    int lasts [2] = '{7, 5};
    int m_addr[2];
    int m_cnt [2];
    int last_a[2];
    bit hist[$];
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    task automatic model_reset();
        hist = '{0, 0, 0, 0};
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0;
            m_cnt[k]  = 0;
            last_a[k] = 0;
        end
    endtask

    // One rising edge's worth of behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit adv, w;
        int na;
        hist.push_front(step);
        void'(hist.pop_back());
        for (int k = 0; k < 2; k++) begin
            adv = 1'b0;
            if (en) begin
                if (mode) begin
                    m_cnt[k] = 0;
                    adv = hist[2] && !hist[3];
                end else begin
                    m_cnt[k]++;
                    if (m_cnt[k] == divs[k]) begin
                        m_cnt[k] = 0;
                        adv = 1'b1;
                    end
                end
            end
            if (adv) begin
                if (dir) begin
                    na = (m_addr[k] + lasts[k]) % (lasts[k] + 1);
                    w  = (m_addr[k] == 0);
                end else begin
                    na = (m_addr[k] + 1) % (lasts[k] + 1);
                    w  = (m_addr[k] == lasts[k]);
                end
                m_addr[k] = na;
                if (k == 0) q0.push_back({w, 3'(na)});
                else        q1.push_back({w, 3'(na)});
            end
        end
    endtask

    task automatic cyc(input logic e, input logic m, input logic d, input logic s);
        @(negedge clk);
        en = e; mode = m; dir = d; step = s;
        model_edge();
    endtask

    task automatic chk(input int k, input logic [2:0] a, input logic t, input logic w);
        logic [3:0] e;
        int sz;
        sz = (k == 0) ? q0.size() : q1.size();
        checks++;
        if (t) begin
            if (sz == 0) begin
                errors++;
                $display("FAIL tick%0d: unexpected tick, addr=%0d wrap=%0b", k, a, w);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (a !== e[2:0] || w !== e[3]) begin
                    errors++;
                    $display("FAIL adv%0d: got addr=%0d wrap=%0b, expected addr=%0d wrap=%0b",
                             k, a, w, e[2:0], e[3]);
                end
                last_a[k] = int'(e[2:0]);
            end
        end else if (sz != 0 || a !== 3'(last_a[k]) || w !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: got addr=%0d wrap=%0b pending=%0d, expected addr=%0d wrap=0 pending=0",
                     k, a, w, sz, last_a[k]);
        end
        checks++;
        if (int'(a) > lasts[k]) begin
            errors++;
            $display("FAIL range%0d: addr=%0d exceeds %0d", k, a, lasts[k]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && !rst) begin
                chk(0, {a2_0, a1_0, a0_0}, tk_0, wr_0);
                chk(1, {a2_1, a1_1, a0_1}, tk_1, wr_1);
            end
        end
    end

    task automatic chk_rst_state(input string nm);
        checks++;
        if ({a2_0, a1_0, a0_0, tk_0, wr_0, a2_1, a1_1, a0_1, tk_1, wr_1} !== 10'd0) begin
            errors++;
            $display("FAIL %s: outputs=%b, expected all zero", nm,
                     {a2_0, a1_0, a0_0, tk_0, wr_0, a2_1, a1_1, a0_1, tk_1, wr_1});
        end
    endtask

    // Reset lands between edges; outputs must clear before the next edge.
    task automatic mid_reset(input int hold_cycles);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_rst_state("async_rst");
        model_reset();
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_edge();
    endtask

    logic r_en, r_mode, r_dir, r_step;

    initial begin
        model_reset();
        #2;
        chk_rst_state("por_rst");
        @(negedge clk);
        rst = 1'b0;
        model_edge();
        mon_on = 1'b1;

        // auto up: full wrap on both instances
        repeat (40) cyc(1, 0, 0, 0);
        // dir flipped mid-count, then counting down through the short wrap
        repeat (2) cyc(1, 0, 0, 0);
        repeat (40) cyc(1, 0, 1, 0);
        // manual: step held 10 clocks, released, pressed again
        cyc(1, 1, 0, 0);
        repeat (10) cyc(1, 1, 0, 1);
        repeat (3) cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 1);
        repeat (4) cyc(1, 1, 0, 0);
        // enable hold in auto mode mid-count
        repeat (6) cyc(1, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);
        repeat (8) cyc(1, 0, 0, 0);
        // step edge while disabled in manual mode must be discarded
        cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 1);
        repeat (5) cyc(0, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);
        // async reset mid-count, then first advance after a full count
        repeat (23) cyc(1, 0, 0, 0);
        mid_reset(2);
        repeat (12) cyc(1, 0, 0, 0);

        r_en = 1'b1; r_mode = 1'b0; r_dir = 1'b0; r_step = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) r_en = ~r_en;
            if (r_en && $urandom_range(0, 15) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
            if ($urandom_range(0, 3) == 0) r_step = ~r_step;
            cyc(r_en, r_mode, r_dir, r_step);
            if ($urandom_range(0, 499) == 0) mid_reset($urandom_range(1, 3));
        end

        repeat (3) cyc(0, r_mode, r_dir, r_step);
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expected advances q0=%0d q1=%0d, expected 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
